// File: rtl/scan_loader.sv
// Scan-chain loader: shifts an image into a serial scan chain MSB first
// and assembles the bits returning on scan_out into readback bytes.
module scan_loader #(
    parameter int IMG_BYTES   = 78,
    parameter bit CLEAR_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       scan_in,
    output logic       scan_en,
    output logic       scan_reset,
    input  logic       scan_out,
    output logic [7:0] rb_data,
    output logic       rb_valid,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(IMG_BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(IMG_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [7:0]      sreg;
    logic [7:0]      sreg_nx;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_nx;
    logic [CW-1:0]   byte_cnt;
    logic [CW-1:0]   byte_nx;
    logic            hs;
    logic            en_nx;
    logic            clr_nx;
    logic            rdy_nx;
    logic            busy_nx;
    logic            done_nx;
    logic [6:0]      rb_sh;

    assign hs      = in_valid && in_ready;
    assign scan_in = sreg[7];

    // Next-state, shifter and counter logic plus next values of registered outputs.
    always_comb begin
        state_nx = state;
        sreg_nx  = sreg;
        bit_nx   = bit_cnt;
        byte_nx  = byte_cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CLEAR_FIRST ? CLEAR : LOAD;
                    bit_nx   = '0;
                    byte_nx  = '0;
                end
            end
            CLEAR: begin
                state_nx = LOAD;
            end
            LOAD: begin
                if (hs) begin
                    sreg_nx  = in_data;
                    bit_nx   = '0;
                    byte_nx  = byte_cnt + 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                sreg_nx = {sreg[6:0], 1'b0};
                bit_nx  = bit_cnt + 1'b1;
                if (bit_cnt == 3'd7) begin
                    if (hs) begin
                        sreg_nx = in_data;
                        bit_nx  = '0;
                        byte_nx = byte_cnt + 1'b1;
                    end else if (byte_cnt < LAST) begin
                        state_nx = LOAD;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        en_nx   = (state_nx == SHIFT);
        clr_nx  = (state_nx == CLEAR);
        rdy_nx  = (state_nx == LOAD) ||
                  ((state_nx == SHIFT) && (bit_nx == 3'd7) && (byte_nx < LAST));
        busy_nx = (state_nx == CLEAR) || (state_nx == LOAD) || (state_nx == SHIFT);
        done_nx = (state_nx == DONE);
    end

    // State, datapath and registered control outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            scan_en    <= 1'b0;
            scan_reset <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            sreg       <= sreg_nx;
            bit_cnt    <= bit_nx;
            byte_cnt   <= byte_nx;
            scan_en    <= en_nx;
            scan_reset <= clr_nx;
            in_ready   <= rdy_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

    // Readback: collect returning bits, publish a byte after every eighth.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rb_sh    <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (scan_en) begin
                rb_sh <= {rb_sh[5:0], scan_out};
                if (bit_cnt == 3'd7) begin
                    rb_data  <= {rb_sh, scan_out};
                    rb_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_loader.sv
// Directed bench for scan_loader: three configurations, each with a
// bench-side scan chain model and a negedge activity monitor.
module tb_scan_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [2:0]      reset;
    logic [2:0]      start;
    logic [2:0]      in_valid;
    logic [2:0][7:0] in_data;
    logic [2:0]      in_ready;
    logic [2:0]      scan_in;
    logic [2:0]      scan_en;
    logic [2:0]      scan_reset;
    logic [2:0]      scan_out;
    logic [2:0][7:0] rb_data;
    logic [2:0]      rb_valid;
    logic [2:0]      busy;
    logic [2:0]      done;
    logic            preload;

    logic [623:0] chain [3];

    int   en_cnt [3];
    int   rst_cnt [3];
    int   done_cnt [3];
    int   rbv_cnt [3];
    int   done_cyc [3];
    logic [7:0] rb_last [3];
    logic bits [3][1024];
    int   en_cyc [3][1024];

    logic [7:0] img [78];

    scan_loader #(.IMG_BYTES(2), .CLEAR_FIRST(1'b1)) u0 (
        .clk(clk), .reset(reset[0]), .start(start[0]),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .scan_in(scan_in[0]), .scan_en(scan_en[0]), .scan_reset(scan_reset[0]),
        .scan_out(scan_out[0]), .rb_data(rb_data[0]), .rb_valid(rb_valid[0]),
        .busy(busy[0]), .done(done[0])
    );

    scan_loader #(.IMG_BYTES(1), .CLEAR_FIRST(1'b0)) u1 (
        .clk(clk), .reset(reset[1]), .start(start[1]),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .scan_in(scan_in[1]), .scan_en(scan_en[1]), .scan_reset(scan_reset[1]),
        .scan_out(scan_out[1]), .rb_data(rb_data[1]), .rb_valid(rb_valid[1]),
        .busy(busy[1]), .done(done[1])
    );

    scan_loader u2 (
        .clk(clk), .reset(reset[2]), .start(start[2]),
        .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .scan_in(scan_in[2]), .scan_en(scan_en[2]), .scan_reset(scan_reset[2]),
        .scan_out(scan_out[2]), .rb_data(rb_data[2]), .rb_valid(rb_valid[2]),
        .busy(busy[2]), .done(done[2])
    );

    assign scan_out[0] = chain[0][15];
    assign scan_out[1] = chain[1][7];
    assign scan_out[2] = chain[2][623];

    // Chain models: 16, 8 and 624 bits long; unit 1 starts out holding 0x3C.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int u = 0; u < 3; u++) begin
            if (preload)
                chain[u] <= (u == 1) ? 624'h3C : 624'h0;
            else if (scan_reset[u])
                chain[u] <= '0;
            else if (scan_en[u])
                chain[u] <= {chain[u][622:0], scan_in[u]};
        end
    end

    // Activity monitor sampled mid-cycle.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (scan_en[u] && en_cnt[u] < 1024) begin
                bits[u][en_cnt[u]]   <= scan_in[u];
                en_cyc[u][en_cnt[u]] <= cyc;
                en_cnt[u]            <= en_cnt[u] + 1;
            end
            if (scan_reset[u])
                rst_cnt[u] <= rst_cnt[u] + 1;
            if (done[u]) begin
                done_cnt[u] <= done_cnt[u] + 1;
                done_cyc[u] <= cyc;
            end
            if (rb_valid[u]) begin
                rbv_cnt[u] <= rbv_cnt[u] + 1;
                rb_last[u] <= rb_data[u];
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte; optionally idle in_valid for gap cycles once ready.
    task automatic push(input int u, input logic [7:0] b, input int gap);
        int n;
        n = 0;
        if (gap > 0) begin
            in_valid[u] = 1'b0;
            while (!in_ready[u] && n < 400) begin
                step();
                n++;
            end
            repeat (gap) step();
        end
        in_valid[u] = 1'b1;
        in_data[u]  = b;
        while (!in_ready[u] && n < 400) begin
            step();
            n++;
        end
        chk("ready_wait", in_ready[u], 1);
        step();
    endtask

    task automatic wait_done(input int u, input int base, input int limit);
        int n;
        n = 0;
        while (done_cnt[u] == base && n < limit) begin
            step();
            n++;
        end
        step();
        step();
    endtask

    // Two-byte load 0x09, 0xA5 on unit 0 with full bookkeeping checks.
    task automatic load_ab(input string tag, input int gap);
        int b_en;
        int b_rst;
        int b_done;
        logic [15:0] seq;
        b_en   = en_cnt[0];
        b_rst  = rst_cnt[0];
        b_done = done_cnt[0];
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        push(0, 8'h09, 0);
        push(0, 8'hA5, gap);
        in_valid[0] = 1'b0;
        wait_done(0, b_done, 200);
        seq = '0;
        for (int i = 0; i < 16; i++)
            seq = {seq[14:0], bits[0][b_en+i]};
        chk({tag, "_clr"}, rst_cnt[0] - b_rst, 1);
        chk({tag, "_en"}, en_cnt[0] - b_en, 16);
        chk({tag, "_gap"}, en_cyc[0][b_en+15] - en_cyc[0][b_en] + 1 - 16, gap);
        chk({tag, "_bits"}, seq, 16'h09A5);
        chk({tag, "_done"}, done_cnt[0] - b_done, 1);
        chk({tag, "_done_at"}, done_cyc[0] - en_cyc[0][b_en+15], 1);
    endtask

    initial begin
        int b_en;
        int b_rst;
        int b_done;
        int b_rbv;
        int mism;

        reset    = '0;
        start    = '0;
        in_valid = '0;
        in_data  = '0;
        preload  = 1'b1;
        repeat (3) step();
        chk("reset_outs", {scan_in[0], scan_en[0], scan_reset[0], in_ready[0],
                           busy[0], done[0], rb_valid[0], rb_data[0]}, 0);
        reset   = '1;
        preload = 1'b0;
        step();

        load_ab("basic", 0);
        load_ab("stall3", 3);

        b_en   = en_cnt[0];
        b_done = done_cnt[0];
        b_rbv  = rbv_cnt[0];
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        push(0, 8'h09, 0);
        in_valid[0] = 1'b0;
        repeat (3) step();
        reset[0] = 1'b0;
        step();
        chk("abort_outs", {scan_en[0], busy[0], done[0]}, 0);
        reset[0] = 1'b1;
        repeat (10) step();
        chk("abort_en", en_cnt[0] - b_en, 4);
        chk("abort_done", done_cnt[0] - b_done, 0);
        chk("abort_rbv", rbv_cnt[0] - b_rbv, 0);
        load_ab("reload", 0);

        b_en   = en_cnt[0];
        b_rst  = rst_cnt[0];
        b_done = done_cnt[0];
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        push(0, 8'h09, 0);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        push(0, 8'hA5, 0);
        in_valid[0] = 1'b0;
        for (int n = 0; n < 200 && !done[0]; n++)
            step();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (30) step();
        chk("ign_done", done_cnt[0] - b_done, 1);
        chk("ign_en", en_cnt[0] - b_en, 16);
        chk("ign_clr", rst_cnt[0] - b_rst, 1);
        chk("idle_ready_busy", {in_ready[0], busy[0]}, 0);

        b_en   = en_cnt[1];
        b_rst  = rst_cnt[1];
        b_done = done_cnt[1];
        b_rbv  = rbv_cnt[1];
        start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        push(1, 8'h5A, 0);
        in_valid[1] = 1'b0;
        wait_done(1, b_done, 200);
        chk("nc_clr", rst_cnt[1] - b_rst, 0);
        chk("nc_en", en_cnt[1] - b_en, 8);
        chk("nc_rbv", rbv_cnt[1] - b_rbv, 1);
        chk("nc_rbdata", rb_last[1], 8'h3C);
        chk("nc_chain", chain[1][7:0], 8'h5A);

        for (int i = 0; i < 78; i++)
            img[i] = 8'($urandom_range(0, 255));
        b_en   = en_cnt[2];
        b_done = done_cnt[2];
        b_rbv  = rbv_cnt[2];
        start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        for (int i = 0; i < 78; i++)
            push(2, img[i], int'($urandom_range(0, 2)));
        in_valid[2] = 1'b0;
        wait_done(2, b_done, 200);
        mism = 0;
        for (int k = 0; k < 78; k++)
            if (chain[2][623-8*k -: 8] !== img[k])
                mism++;
        chk("img_en", en_cnt[2] - b_en, 624);
        chk("img_rbv", rbv_cnt[2] - b_rbv, 78);
        chk("img_rbdata", rb_last[2], 8'h00);
        chk("img_chain", mism, 0);
        chk("img_done", done_cnt[2] - b_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
